// File: rtl/signal_debounce_pkg.sv
// signal_debounce_pkg
// Shared types and constants for the signal_debounce block.
//   state_t         : debounce FSM states (IDLE / QUAL)
//   GLITCH_CNT_W    : width of the rejected-candidate counter
//   GLITCH_CNT_MAX  : saturation value of that counter
//   cnt_width()     : stability counter width, never below 1 bit
package signal_debounce_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } state_t;

  localparam int GLITCH_CNT_W = 16;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = '1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/signal_debounce_sync.sv
// bit_sync
// Parameterised-depth synchroniser for one asynchronous bit.
//   clk : sampling clock
//   rst : synchronous active-high reset, loads INIT into every stage
//   d   : asynchronous input
//   q   : synchronised output (last stage)
module bit_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("bit_sync: STAGES must be >= 2");
  end

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= {STAGES{INIT}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/signal_debounce.sv
// signal_debounce
// Synchronises a slow noisy level input and only lets a new level through
// once it has persisted, so downstream logic sees one transition per real
// input change.
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   in         : raw asynchronous level
//   out        : debounced level (registered)
//   busy       : high while a candidate change is being qualified (registered)
//   glitch_cnt : saturating count of rejected candidates; exists only when
//                SIGNAL_DEBOUNCE_GLITCH_CNT_EN is defined
module signal_debounce
  import signal_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 1000,
  parameter logic INIT          = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in,
  output logic                    out,
  output logic                    busy
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("signal_debounce: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("signal_debounce: STABLE_CYCLES must be >= 1");
  end

  localparam int             CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt, busy_nxt;
  logic             reject;

  bit_sync #(
    .STAGES(SYNC_STAGES),
    .INIT  (INIT)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (in),
    .q  (s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (s != out) state_nxt = QUAL;
      // an inverted candidate equals out again, so it falls out as a reject
      QUAL: if (s == out || cnt == CNT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output / datapath next values
  always_comb begin
    cnt_nxt = cnt;
    out_nxt = out;
    reject  = 1'b0;
    unique case (state)
      IDLE: if (s != out) cnt_nxt = '0;
      QUAL: begin
        if (s == out)             reject  = 1'b1;
        else if (cnt == CNT_LAST) out_nxt = s;
        else                      cnt_nxt = cnt + 1'b1;
      end
      default: cnt_nxt = '0;
    endcase
    // busy is registered from the next state so it tracks state exactly
    busy_nxt = (state_nxt == QUAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      out  <= INIT;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      out  <= out_nxt;
      busy <= busy_nxt;
    end
  end

`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_q;

  always_ff @(posedge clk) begin
    if (rst)
      glitch_q <= '0;
    else if (reject && glitch_q != GLITCH_CNT_MAX)
      glitch_q <= glitch_q + 1'b1;
  end

  assign glitch_cnt = glitch_q;
`else
  logic unused_reject;
  assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_signal_debounce.sv
module tb_signal_debounce;
  localparam int   SYNC   = 2;
  localparam int   STABLE = 4;
  localparam logic INIT   = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b0;
  logic out, busy;
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
  logic [15:0] glitch_cnt;
`endif

  always #5 clk = ~clk;

  signal_debounce #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .INIT         (INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out),
    .busy(busy)
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  typedef struct packed {
    logic        out;
    logic        busy;
    logic [15:0] glitch;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   rise_cnt = 0;
  logic prev_out = INIT;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchroniser is a plain delay line; the filter is
  // described by run lengths of samples that differ from the current output.
  // A run reaching STABLE+1 samples flips the output, a shorter run that ends
  // counts as one glitch.
  logic        hist[SYNC];
  logic        samp;
  logic        m_out = INIT;
  int          m_run = 0;
  logic [15:0] m_glitch = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC; i++) hist[i] = INIT;
      m_out    = INIT;
      m_run    = 0;
      m_glitch = '0;
    end else begin
      samp = hist[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = in;
      if (samp != m_out) begin
        m_run++;
        if (m_run == STABLE + 1) begin
          m_out = samp;
          m_run = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch != 16'hFFFF) m_glitch = m_glitch + 16'd1;
        m_run = 0;
      end
    end
    exp_q.push_back('{out: m_out, busy: (m_run > 0), glitch: m_glitch});
  end

  // Monitor: one expected entry per clock, compared away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_out", int'(out), int'(e.out));
      chk("sb_busy", int'(busy), int'(e.busy));
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
      chk("sb_glitch", int'(glitch_cnt), int'(e.glitch));
`endif
    end
    if (out === 1'b1 && prev_out === 1'b0) rise_cnt++;
    prev_out = out;
  end

  task automatic drive(input logic v, input int n);
    in = v;
    repeat (n) @(negedge clk);
  endtask

  // Edge index (edge 0 = first edge sampling the current in) at which out
  // reaches v; bounded so a stuck output still ends the test.
  task automatic measure(input logic v, output int lat);
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
    end while (out !== v && lat < 60);
  endtask

  task automatic chk_glitch(input string name, input int exp);
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
    chk(name, int'(glitch_cnt), exp);
`endif
  endtask

  initial begin
    int lat;
    int rise_base;

    // reset with input high
    rst = 1'b1;
    in  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out", int'(out), 0);
      chk("rst_busy", int'(busy), 0);
      chk_glitch("rst_glitch", 0);
    end
    rst = 1'b0;
    in  = 1'b0;
    repeat (4) @(negedge clk);

    // clean rise and fall
    in = 1'b1;
    measure(1'b1, lat);
    chk("rise_lat", lat, SYNC + STABLE);
    chk_glitch("rise_glitch", 0);
    repeat (2) @(negedge clk);
    in = 1'b0;
    measure(1'b0, lat);
    chk("fall_lat", lat, SYNC + STABLE);
    repeat (2) @(negedge clk);

    // boundary pulses: STABLE samples rejected, STABLE+1 accepted
    drive(1'b1, STABLE);
    drive(1'b0, 10);
    chk("pulse4_out", int'(out), 0);
    chk_glitch("pulse4_glitch", 1);
    drive(1'b1, STABLE + 1);
    drive(1'b0, 2);
    chk("pulse5_out", int'(out), 1);
    chk_glitch("pulse5_glitch", 1);
    drive(1'b0, 10);
    chk("pulse5_back", int'(out), 0);

    // bounce burst
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rise_base = rise_cnt;
    repeat (5) begin
      drive(1'b1, 2);
      drive(1'b0, 2);
    end
    in = 1'b1;
    measure(1'b1, lat);
    chk("bounce_lat", lat, SYNC + STABLE);
    chk_glitch("bounce_glitch", 5);
    repeat (4) @(negedge clk);
    chk("bounce_rises", rise_cnt - rise_base, 1);
    drive(1'b0, 10);

    // reset while qualifying (rst sampled at edge 4)
    in = 1'b1;
    repeat (4) @(negedge clk);
    chk("midq_busy_pre", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midq_out", int'(out), 0);
    chk("midq_busy", int'(busy), 0);
    rst = 1'b0;
    measure(1'b1, lat);
    chk("midq_lat", lat, SYNC + STABLE);
    drive(1'b0, 10);

    // random levels with occasional resets
    repeat (300) begin
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
    end
    drive(1'b0, 10);

    // glitch counter saturation
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    repeat (65540) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end
    drive(1'b0, 10);
    chk("sat_out", int'(out), 0);
    chk_glitch("sat_glitch", 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
